ook_rf_modulator: RTL

- Serial RF keying stage that drives the board's rf output pin.
- Accepts bytes over a valid/ready handshake, frames them (start bit, 8 data bits MSB-first, stop bit) and gates an NCO-generated square-wave carrier per bit: on-off keying (OOK).
- Replaces driving rf directly from a raw clock pin; a free-running phase accumulator sets the carrier frequency.

---
 rtl/ook_rf_modulator_pkg.sv | 21 ++
 rtl/ook_rf_modulator_nco.sv | 20 ++
 rtl/ook_rf_modulator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ook_rf_modulator_pkg.sv
// Shared types and framing constants for the OOK RF modulator and related RF stages.
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int   FRAME_BITS  = 10;
  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;

  // Width of a counter spanning 0..div-1; never narrower than one bit.
  function automatic int baud_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/ook_rf_modulator_nco.sv
// Free-running phase accumulator; the carrier is the accumulator MSB (50% duty square wave).
module rf_nco #(
  parameter int ACC_W = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [ACC_W-1:0] inc,
  output logic             carrier
);

  logic [ACC_W-1:0] acc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) acc <= '0;
    else     acc <= acc + inc;
  end

  assign carrier = acc[ACC_W-1];

endmodule

// File: rtl/ook_rf_modulator.sv
// Framed byte transmitter that keys an NCO carrier onto rf (OOK by default).
// Define OOK_RF_FSK_EN to switch to phase-continuous 2-FSK with a PHASE_INC0 space tone.
module ook_rf_modulator
  import rf_pkg::*;
#(
  parameter int             ACC_W     = 24,
  parameter logic [ACC_W-1:0] PHASE_INC = 24'd1398101,
  parameter int             BAUD_DIV  = 1000
`ifdef OOK_RF_FSK_EN
  , parameter logic [ACC_W-1:0] PHASE_INC0 = PHASE_INC >> 1
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       rf
);

  localparam int                CNT_W     = baud_cnt_w(BAUD_DIV);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_n;
  logic [BIT_W-1:0] bit_cnt, bit_n;
  logic [7:0]       shift, shift_n;
  logic             key;
  logic             accept;
  logic             period_end;
  logic [ACC_W-1:0] inc;
  logic             carrier;

  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = tx_valid & tx_ready;
  assign period_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    key     = 1'b0;
    if (state != IDLE) baud_n = period_end ? '0 : baud_cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (accept) begin
          shift_n = tx_data;
          baud_n  = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        key = START_LEVEL;
        if (period_end) state_n = DATA;
      end
      DATA: begin
        key = shift[7];
        if (period_end) begin
          shift_n = {shift[6:0], 1'b0};
          bit_n   = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) state_n = STOP;
        end
      end
      STOP: begin
        key = STOP_LEVEL;
        if (period_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef OOK_RF_FSK_EN
  // Tone select only changes the increment, so phase stays continuous across bit edges.
  assign inc = key ? PHASE_INC : PHASE_INC0;
`else
  assign inc = PHASE_INC;
`endif

  rf_nco #(
    .ACC_W (ACC_W)
  ) u_nco (
    .CLK     (CLK),
    .RST     (RST),
    .inc     (inc),
    .carrier (carrier)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf <= 1'b0;
    end else begin
`ifdef OOK_RF_FSK_EN
      rf <= (state != IDLE) & carrier;
`else
      rf <= key & carrier;
`endif
    end
  end

endmodule
